// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and flag-update-mask definitions for the ALU
// writeback path.
package alu_pkg;

    localparam logic [4:0] OP_INC = 5'b00001;
    localparam logic [4:0] OP_DEC = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SBB = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_XOR = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_SHL = 5'b10000;
    localparam logic [4:0] OP_SHR = 5'b10001;
    localparam logic [4:0] OP_SAL = 5'b10010;
    localparam logic [4:0] OP_SAR = 5'b10011;
    localparam logic [4:0] OP_ROL = 5'b10100;
    localparam logic [4:0] OP_ROR = 5'b10101;
    localparam logic [4:0] OP_RCL = 5'b10110;
    localparam logic [4:0] OP_RCR = 5'b10111;

    localparam int FLG_CF = 0;
    localparam int FLG_PF = 1;
    localparam int FLG_AF = 2;
    localparam int FLG_ZF = 3;
    localparam int FLG_SF = 4;
    localparam int FLG_OF = 5;

    // upd: bits copied from ALU status; zero: bits forced to 0; rest held.
    typedef struct packed {
        logic [5:0] upd;
        logic [5:0] zero;
    } flag_mask_t;

    function automatic flag_mask_t flag_mask(input logic [4:0] f);
        flag_mask_t m;
        m.upd  = '0;
        m.zero = '0;
        case (f)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: m.upd = '1;
            OP_INC, OP_DEC: begin
                m.upd         = '1;
                m.upd[FLG_CF] = 1'b0;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                m.upd[FLG_PF]  = 1'b1;
                m.upd[FLG_ZF]  = 1'b1;
                m.upd[FLG_SF]  = 1'b1;
                m.zero[FLG_CF] = 1'b1;
                m.zero[FLG_AF] = 1'b1;
                m.zero[FLG_OF] = 1'b1;
            end
            OP_SHL, OP_SHR, OP_SAL, OP_SAR: begin
                m.upd         = '1;
                m.upd[FLG_AF] = 1'b0;
            end
            OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
                m.upd[FLG_CF] = 1'b1;
                m.upd[FLG_OF] = 1'b1;
            end
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with a registered write-ready, so a pop never
// propagates combinationally to the producer side.
module alu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ready_q, wr_ready_d;
    logic          do_push, do_pop;

    assign rd_valid = (count_q != '0);
    assign wr_ready = wr_ready_q;
    assign rd_data  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && wr_ready_q;
        do_pop   = pop && rd_valid;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        wr_ready_d = (count_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is cleared on reset so the head reads as zero
            // afterwards; cheap here because the FIFO is only a few entries.
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_ready_q <= wr_ready_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU writeback stage: architectural flag register with per-opcode update
// masks, CF feedback to the ALU, and a small result/flag-snapshot FIFO.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_f,
    input  logic [W-1:0] in_result,
    input  logic [5:0]   in_status,
    input  logic         set_cf,
    input  logic         clr_cf,
    output logic         cf_out,
    output logic [5:0]   flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [5:0]   out_flags,
    output logic         illegal
);

    logic [5:0] flags_q, flags_d;
    logic       illegal_q, illegal_d;
    logic       accept;
    flag_mask_t mask;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        mask      = flag_mask(in_f);
        accept    = in_valid && in_ready;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        if (accept) begin
            flags_d = (flags_q & ~(mask.upd | mask.zero)) | (in_status & mask.upd);
            if (mask.upd == '0) begin
                illegal_d = 1'b1;
            end
        end
        // Explicit CLC/STC win over the accepted op and also land in its snapshot.
        if (clr_cf) begin
            flags_d[FLG_CF] = 1'b0;
        end else if (set_cf) begin
            flags_d[FLG_CF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign flags   = flags_q;
    assign cf_out  = flags_q[FLG_CF];
    assign illegal = illegal_q;

    alu_result_fifo #(
        .DEPTH(DEPTH),
        .DW   (W + 6)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .pop     (out_ready),
        .wr_data ({in_result, flags_d}),
        .wr_ready(in_ready),
        .rd_valid(out_valid),
        .rd_data ({out_result, out_flags})
    );

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios followed by
// randomized traffic checked against a behavioural flag/FIFO model.
module tb_alu_result_stage;

    localparam int DEPTH = 2;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_f;
    logic [W-1:0] in_result;
    logic [5:0]   in_status;
    logic         set_cf;
    logic         clr_cf;
    logic         cf_out;
    logic [5:0]   flags;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [5:0]   out_flags;
    logic         illegal;

    alu_result_stage #(.DEPTH(DEPTH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_f      (in_f),
        .in_result (in_result),
        .in_status (in_status),
        .set_cf    (set_cf),
        .clr_cf    (clr_cf),
        .cf_out    (cf_out),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_flags (out_flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W+5:0] sb_q[$];
    logic [5:0]   m_flags;
    logic         m_illegal;
    logic         m_ready;
    int           m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flag rules by opcode class; legal=0 for unused opcodes.
    function automatic logic [5:0] ref_flags(input logic [5:0] old, input logic [4:0] f,
                                             input logic [5:0] st, output logic legal);
        logic [5:0] n;
        n     = old;
        legal = 1'b1;
        if (f >= 5'd4 && f <= 5'd7) begin
            n = st;
        end else if (f == 5'd1 || f == 5'd3) begin
            n    = st;
            n[0] = old[0];
        end else if (f >= 5'd8 && f <= 5'd11) begin
            n    = 6'b000000;
            n[1] = st[1];
            n[3] = st[3];
            n[4] = st[4];
        end else if (f >= 5'd16 && f <= 5'd19) begin
            n    = st;
            n[2] = old[2];
        end else if (f >= 5'd20 && f <= 5'd23) begin
            n[0] = st[0];
            n[5] = st[5];
        end else begin
            legal = 1'b0;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_flags   = '0;
        m_illegal = 1'b0;
        m_ready   = 1'b0;
        m_cnt     = 0;
        sb_q.delete();
    endtask

    // One clock: drive inputs, check state at negedge, advance model at posedge.
    task automatic step(input logic r, input logic v, input logic [4:0] f,
                        input logic [W-1:0] res, input logic [5:0] st,
                        input logic s, input logic c, input logic o);
        logic       acc, pop, leg;
        logic [5:0] nf;
        rst = r; in_valid = v; in_f = f; in_result = res; in_status = st;
        set_cf = s; clr_cf = c; out_ready = o;
        @(negedge clk);
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_cnt != 0);
        check("flags", flags, m_flags);
        check("cf_out", cf_out, m_flags[0]);
        check("illegal", illegal, m_illegal);
        acc = v && m_ready;
        pop = o && (m_cnt != 0);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            nf  = m_flags;
            leg = 1'b1;
            if (acc) nf = ref_flags(m_flags, f, st, leg);
            if (c) nf[0] = 1'b0;
            else if (s) nf[0] = 1'b1;
            if (acc) begin
                sb_q.push_back({res, nf});
                if (!leg) m_illegal = 1'b1;
            end
            m_flags = nf;
            m_cnt   = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
            m_ready = (m_cnt != DEPTH);
        end
        #1;
    endtask

    // Monitor: compares the FIFO head against the scoreboard on each pop.
    initial begin
        logic [W+5:0] exp;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=pop required=no_pop at %0t", $time);
                end else begin
                    exp = sb_q.pop_front();
                    check("out_result", out_result, exp[W+5:6]);
                    check("out_flags", out_flags, exp[5:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_f = '0; in_result = '0; in_status = '0;
        set_cf = 1'b0; clr_cf = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_out_result", out_result, 16'h0000);
        check("rst_out_flags", out_flags, 6'b000000);
        check("rst_in_ready", in_ready, 1'b0);

        // Reset release, then ADD and a dependent ADC back-to-back.
        step(0, 0, 5'd0, 16'h0, 6'b0, 0, 0, 1);
        check("ready_after_rst", in_ready, 1'b1);
        step(0, 1, 5'b00100, 16'h0009, 6'b000010, 0, 0, 1);
        check("add_out_valid", out_valid, 1'b1);
        check("add_out_result", out_result, 16'h0009);
        check("add_flags", flags, 6'b000010);
        check("add_cf", cf_out, 1'b0);
        step(0, 1, 5'b00101, 16'h1234, 6'b000001, 0, 0, 1);
        check("adc_cf", cf_out, 1'b1);

        // INC keeps CF.
        step(0, 1, 5'b00001, 16'h0010, 6'b000100, 0, 0, 1);
        check("inc_flags", flags, 6'b000101);

        // Logic op force-clears CF/AF/OF.
        step(0, 1, 5'b00100, 16'hffff, 6'b111111, 0, 0, 1);
        step(0, 1, 5'b01000, 16'h5013, 6'b100101, 0, 0, 1);
        check("and_flags", flags, 6'b000000);

        // Rotate touches only CF and OF.
        step(0, 1, 5'b00100, 16'h0001, 6'b011110, 0, 0, 1);
        step(0, 1, 5'b10111, 16'h8000, 6'b100001, 0, 0, 1);
        check("rcr_flags", flags, 6'b111111);

        // CLC in the same cycle as an accept overrides CF and its snapshot.
        step(0, 1, 5'b00100, 16'h00aa, 6'b000001, 0, 1, 1);
        check("clr_cf", cf_out, 1'b0);
        check("clr_snap_result", out_result, 16'h00aa);
        check("clr_snap_cf", out_flags[0], 1'b0);

        // Backpressure: fill, third op refused, then drain across a wrap.
        step(0, 0, 5'd0, 16'h0, 6'b0, 0, 0, 1);
        step(0, 1, 5'b00110, 16'h0a01, 6'b000000, 0, 0, 0);
        step(0, 1, 5'b00110, 16'h0a02, 6'b001000, 0, 0, 0);
        check("full_in_ready", in_ready, 1'b0);
        step(0, 1, 5'b00110, 16'h0a03, 6'b010000, 0, 0, 0);
        check("full_hold_result", out_result, 16'h0a01);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 5'b10000, 16'h0b00 + 16'(i), 6'(i), 0, 0, 1);
        end
        step(0, 0, 5'd0, 16'h0, 6'b0, 0, 0, 1);
        step(0, 0, 5'd0, 16'h0, 6'b0, 0, 0, 1);

        // Unused opcode.
        step(0, 1, 5'b00010, 16'h0dd0, 6'b111111, 0, 0, 1);
        check("illegal_set", illegal, 1'b1);
        check("illegal_result", out_result, 16'h0dd0);

        // Mid-operation reset with two entries buffered.
        step(0, 1, 5'b00100, 16'h0c01, 6'b000011, 0, 0, 0);
        step(0, 1, 5'b00100, 16'h0c02, 6'b000101, 0, 0, 0);
        step(1, 1, 5'b00100, 16'h0c03, 6'b111111, 0, 0, 1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_flags", flags, 6'b000000);
        check("midrst_illegal", illegal, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        step(0, 0, 5'd0, 16'h0, 6'b0, 0, 0, 1);
        check("midrst_ready_back", in_ready, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, s, c;
            r = ($urandom_range(0, 127) == 0);
            s = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 9) == 0);
            step(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
                 6'($urandom), s, c, 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(0, 0, 5'd0, 16'h0, 6'b0, 0, 0, 1);
        end
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
